noc_port_buffer: RTL and testbench

//  Ingress buffer between one traffic PE and its NoC switch port. Accepts
//  {dest,payload} flits from the PE over a valid/ready handshake and stores them
//  in a DEPTH-entry FIFO. Presents the head flit, with its destination field

---
 rtl/noc_pkg.sv | 17 +
 rtl/noc_port_buffer_if.sv | 31 +++
 rtl/noc_fifo_mem.sv | 23 ++
 rtl/noc_port_buffer.sv | 87 ++++++++
 tb/tb_noc_port_buffer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: field widths, the flit layout and a destination accessor.
package noc_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int FLIT_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] payload;
  } flit_t;

  function automatic logic [ADDR_W-1:0] flit_dest(flit_t f);
    return f.dest;
  endfunction

endpackage

// File: rtl/noc_port_buffer_if.sv
// Handshake bundle between the PE, the port buffer and the switch port.
interface noc_port_buffer_if
  import noc_pkg::*;
#(
  parameter int AddressWidth = ADDR_W,
  parameter int TotalWidth   = FLIT_W,
  parameter int PtrWidth     = 2
);

  logic [TotalWidth-1:0]   i_data;
  logic                    i_data_valid;
  logic                    o_data_ready;
  logic [TotalWidth-1:0]   o_data;
  logic                    o_data_valid;
  logic                    i_data_ready;
  logic [AddressWidth-1:0] o_dest;
  logic [PtrWidth:0]       o_level;
  logic [31:0]             o_in_count;
  logic [31:0]             o_out_count;

  modport master (
    output i_data, i_data_valid, i_data_ready,
    input  o_data_ready, o_data, o_data_valid, o_dest, o_level, o_in_count, o_out_count
  );

  modport slave (
    input  i_data, i_data_valid, i_data_ready,
    output o_data_ready, o_data, o_data_valid, o_dest, o_level, o_in_count, o_out_count
  );

endinterface

// File: rtl/noc_fifo_mem.sv
// Flit storage: synchronous write, asynchronous read, no reset on the array.
module noc_fifo_mem #(
  parameter int Width     = 35,
  parameter int Depth     = 4,
  parameter int AddrWidth = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/noc_port_buffer.sv
// Ingress FIFO between a PE and its switch port, with accepted/forwarded flit counters.
module noc_port_buffer
  import noc_pkg::*;
#(
  parameter int AddressWidth = ADDR_W,
  parameter int DataWidth    = DATA_W,
  parameter int TotalWidth   = FLIT_W,
  parameter int Depth        = 4,
  parameter int PtrWidth     = 2
) (
  input  logic            clk,
  input  logic            rst,
  noc_port_buffer_if.slave bus
);

  generate
    if (TotalWidth != AddressWidth + DataWidth || Depth != 2**PtrWidth) begin : g_param_check
      $fatal(1, "noc_port_buffer: inconsistent width/depth parameters");
    end
  endgenerate

  localparam logic [PtrWidth:0] LevelFull = (PtrWidth+1)'(Depth);

  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [PtrWidth:0]   level;
  logic [31:0]         in_count;
  logic [31:0]         out_count;
  logic [TotalWidth-1:0] head;
  logic                push;
  logic                pop;

  // Ready depends on occupancy only, so a full buffer refuses a push even when popping.
  assign bus.o_data_ready = ~rst & (level != LevelFull);
  assign bus.o_data_valid = (level != '0);
  assign push = bus.i_data_valid & bus.o_data_ready;
  assign pop  = bus.o_data_valid & bus.i_data_ready;

  noc_fifo_mem #(
    .Width    (TotalWidth),
    .Depth    (Depth),
    .AddrWidth(PtrWidth)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(bus.i_data),
    .raddr(rd_ptr),
    .rdata(head)
  );

  // Masking while empty keeps stale or uninitialised entries off the output.
  assign bus.o_data = bus.o_data_valid ? head : '0;

  generate
    if (TotalWidth == FLIT_W && AddressWidth == ADDR_W) begin : g_pkg_dest
      assign bus.o_dest = flit_dest(flit_t'(bus.o_data));
    end else begin : g_raw_dest
      assign bus.o_dest = bus.o_data[TotalWidth-1:DataWidth];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push) in_count  <= in_count + 32'd1;
      if (pop)  out_count <= out_count + 32'd1;
    end
  end

  assign bus.o_level     = level;
  assign bus.o_in_count  = in_count;
  assign bus.o_out_count = out_count;

endmodule

// File: tb/tb_noc_port_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_noc_port_buffer;
  import noc_pkg::*;

  localparam int Depth = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_port_buffer_if #(.AddressWidth(ADDR_W), .TotalWidth(FLIT_W), .PtrWidth(2)) bif ();

  noc_port_buffer #(
    .AddressWidth(ADDR_W),
    .DataWidth   (DATA_W),
    .TotalWidth  (FLIT_W),
    .Depth       (Depth),
    .PtrWidth    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  flit_t             q[$];
  logic [31:0]       m_in, m_out;
  logic [DATA_W-1:0] popped[$];
  bit                record;

  // Reference model: the buffer is just a bounded queue; pop is taken before push each edge.
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst) begin
      q.delete();
      m_in  = 32'd0;
      m_out = 32'd0;
    end else begin
      do_pop  = (q.size() > 0) && (bif.i_data_ready === 1'b1);
      do_push = (bif.i_data_valid === 1'b1) && (q.size() < Depth);
      if (do_pop) begin
        if (record) popped.push_back(q[0].payload);
        void'(q.pop_front());
        m_out++;
      end
      if (do_push) begin
        q.push_back(flit_t'(bif.i_data));
        m_in++;
      end
    end
    #1;
    chk("ready", bif.o_data_ready, (!rst && q.size() < Depth));
    chk("valid", bif.o_data_valid, (q.size() != 0));
    chk("level", bif.o_level, q.size());
    chk("in_count", bif.o_in_count, m_in);
    chk("out_count", bif.o_out_count, m_out);
    chk("count_invariant", 32'(bif.o_in_count - bif.o_out_count), 32'(bif.o_level));
    if (q.size() != 0) begin
      chk("data", bif.o_data, q[0]);
      chk("dest", bif.o_dest, q[0].dest);
    end
  end

  logic [2:0] dests [100];

  initial begin
    int idx, cyc, bad;
    bit will;
    for (int i = 0; i < 100; i++) dests[i] = 3'($urandom);
    record = 1'b0;

    // Test 1: reset held with valid asserted
    rst = 1'b1;
    bif.i_data_valid = 1'b1;
    bif.i_data = {3'($urandom), 32'($urandom)};
    bif.i_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_ready_in_reset", bif.o_data_ready, 0);
    chk("t1_valid_in_reset", bif.o_data_valid, 0);
    chk("t1_in_count_reset", bif.o_in_count, 0);
    chk("t1_out_count_reset", bif.o_out_count, 0);
    chk("t1_data_reset", bif.o_data, 0);
    rst = 1'b0;
    bif.i_data_valid = 1'b0;
    @(negedge clk);
    chk("t1_ready_after_release", bif.o_data_ready, 1);

    // Test 2: single flit
    bif.i_data = {3'd5, 32'd100};
    bif.i_data_valid = 1'b1;
    bif.i_data_ready = 1'b1;
    @(negedge clk);
    bif.i_data_valid = 1'b0;
    chk("t2_valid", bif.o_data_valid, 1);
    chk("t2_dest", bif.o_dest, 5);
    chk("t2_payload", bif.o_data[31:0], 100);
    @(negedge clk);
    chk("t2_out_count", bif.o_out_count, 1);
    chk("t2_level", bif.o_level, 0);

    // Test 3: fill with the switch stalled
    bif.i_data_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bif.i_data = {3'(k), 32'(1000 + k)};
      bif.i_data_valid = 1'b1;
      @(negedge clk);
    end
    bif.i_data = {3'd4, 32'd1004};
    @(negedge clk);
    chk("t3_ready_full", bif.o_data_ready, 0);
    chk("t3_level_full", bif.o_level, 4);
    chk("t3_in_count", bif.o_in_count, 5);
    @(negedge clk);
    chk("t3_level_held", bif.o_level, 4);

    // Test 4: full with pop and push offered together
    bif.i_data_ready = 1'b1;
    @(negedge clk);
    chk("t4_level_pop_only", bif.o_level, 3);
    chk("t4_head_after_pop", bif.o_data[31:0], 1001);
    @(negedge clk);
    chk("t4_level_push_pop", bif.o_level, 3);
    chk("t4_head_fifo", bif.o_data[31:0], 1002);
    chk("t4_in_count", bif.o_in_count, 6);
    bif.i_data_valid = 1'b0;
    bif.i_data_ready = 1'b0;
    @(negedge clk);
    chk("t4_level_idle", bif.o_level, 3);

    // Test 6: mid-run reset discards contents
    rst = 1'b1;
    bif.i_data_valid = 1'b1;
    bif.i_data = {3'($urandom), 32'($urandom)};
    @(negedge clk);
    rst = 1'b0;
    bif.i_data_valid = 1'b0;
    chk("t6_level", bif.o_level, 0);
    chk("t6_valid", bif.o_data_valid, 0);
    chk("t6_in_count", bif.o_in_count, 0);
    chk("t6_out_count", bif.o_out_count, 0);
    bif.i_data_ready = 1'b1;
    @(negedge clk);
    chk("t6_no_stale", bif.o_data_valid, 0);
    chk("t6_out_count_after", bif.o_out_count, 0);

    // Test 5: streaming 100 flits against a randomly stalling switch
    popped.delete();
    record = 1'b1;
    idx = 0;
    cyc = 0;
    while ((idx < 100 || bif.o_level != 0) && cyc < 2000) begin
      bif.i_data_ready = 1'($urandom_range(0, 1));
      if (idx < 100) begin
        bif.i_data_valid = 1'b1;
        bif.i_data = {dests[idx], 32'(idx)};
        will = bif.o_data_ready;
      end else begin
        bif.i_data_valid = 1'b0;
        bif.i_data = {3'($urandom), 32'($urandom)};
        will = 1'b0;
      end
      @(negedge clk);
      if (will) idx++;
      cyc++;
    end
    bif.i_data_valid = 1'b0;
    bif.i_data_ready = 1'b0;
    chk("t5_finished_in_budget", (cyc < 2000), 1);
    chk("t5_in_count", bif.o_in_count, 100);
    chk("t5_out_count", bif.o_out_count, 100);
    chk("t5_level", bif.o_level, 0);
    chk("t5_popped_count", popped.size(), 100);
    bad = 0;
    for (int i = 0; i < popped.size(); i++) if (popped[i] != 32'(i)) bad++;
    chk("t5_order", bad, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
